// File: rtl/exmem_pkg.sv
// exmem_pkg: shared state encoding and helpers for the
// prefetching slow-memory Wishbone slave.
package exmem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_WAIT,
    S_FILL,
    S_WR_WAIT,
    S_ACK
  } state_t;

  // Out-of-window reads return all bits equal to this value.
  localparam logic OOB_BIT = 1'b0;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/exmem_sram.sv
// exmem_sram: single-port synchronous SRAM with byte write
// enables and a registered 1-cycle read (read-before-write).
module exmem_sram #(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS),
  parameter int SEL_W     = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic [AW-1:0]     i_addr,
  input  logic [SEL_W-1:0]  i_be,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < SEL_W; b++) begin
      if (i_be[b]) begin
        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/exmem_pf.sv
// exmem_pf: slow external-memory emulator with a one-line
// prefetch buffer so sequential fetches hit in one cycle.
module exmem_pf
  import exmem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h3800_0000,
  parameter int          RD_DELAY  = 10,
  parameter int          WR_DELAY  = 2,
  parameter int          PF_DEPTH  = 4,
  parameter bit          PF_EN     = 1'b1,
  parameter int          SEL_W     = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wb_valid,
  input  logic              wbs_we_i,
  input  logic [SEL_W-1:0]  wbs_sel_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              pf_hit_o
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(PF_DEPTH);
  localparam int TW = AW - PW;
  localparam int DMAX = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int CW = cnt_w(DMAX);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_fidx;
  logic              r_lvalid;
  logic [TW-1:0]     r_ltag;
  logic [DATA_W-1:0] r_line [PF_DEPTH];
  logic [AW-1:0]     r_widx;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_wdat;
  logic              r_abort;
  logic              r_post_ack;
  logic              r_ack;
  logic              r_hit;
  logic [DATA_W-1:0] r_dat;

  logic [29:0]       w_wfull;
  logic              w_oob;
  logic [AW-1:0]     w_widx;
  logic [TW-1:0]     w_tag;
  logic [PW-1:0]     w_woff;
  logic [PW-1:0]     r_woff;
  logic              w_hit;
  logic              w_start;
  logic [PW-1:0]     w_fnext;
  logic              w_rd_last;
  logic              w_wr_last;
  logic              w_fill_last;
  logic              w_commit;
  logic              w_merge;
  logic [AW-1:0]     w_addr;
  logic [SEL_W-1:0]  w_be;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_fill_word;

  assign w_wfull = 30'((wbs_adr_i - BASE_ADDR) >> 2);
  assign w_oob   = (wbs_adr_i < BASE_ADDR)
                || (w_wfull >= 30'(MEM_WORDS));
  assign w_widx  = w_wfull[AW-1:0];
  assign w_tag   = w_widx[AW-1:PW];
  assign w_woff  = w_widx[PW-1:0];
  assign r_woff  = r_widx[PW-1:0];

  assign w_hit   = PF_EN && r_lvalid && (w_tag == r_ltag);
  assign w_start = (r_state == S_IDLE) && wb_valid && !r_post_ack;

  assign w_fnext     = r_fidx + 1'b1;
  assign w_rd_last   = (r_cnt == CW'(RD_DELAY - 1));
  assign w_wr_last   = (r_cnt == CW'(WR_DELAY - 1));
  assign w_fill_last = (r_fidx == PW'(PF_DEPTH - 1));

  // A write commits only if the master still holds the request.
  assign w_commit = (r_state == S_WR_WAIT) && w_wr_last && wb_valid;
  assign w_merge  = w_commit && r_lvalid
                 && (r_widx[AW-1:PW] == r_ltag);
  assign w_be     = w_commit ? r_sel : '0;

  // Last fill word lands in the same edge that loads dat_o.
  assign w_fill_word = (r_fidx == r_woff) ? w_rdata
                                          : r_line[r_woff];

  always_comb begin
    w_addr = r_widx;
    if (r_state == S_FILL_WAIT) begin
      w_addr = {r_ltag, {PW{1'b0}}};
    end else if (r_state == S_FILL) begin
      w_addr = {r_ltag, w_fnext};
    end
  end

  exmem_sram #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_sram (
    .i_clk   (wb_clk_i),
    .i_addr  (w_addr),
    .i_be    (w_be),
    .i_wdata (r_wdat),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fidx     <= '0;
      r_lvalid   <= 1'b0;
      r_ltag     <= '0;
      r_widx     <= '0;
      r_sel      <= '0;
      r_wdat     <= '0;
      r_abort    <= 1'b0;
      r_post_ack <= 1'b0;
      r_ack      <= 1'b0;
      r_hit      <= 1'b0;
      r_dat      <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        r_line[i] <= '0;
      end
    end else begin
      r_ack      <= 1'b0;
      r_hit      <= 1'b0;
      r_post_ack <= (r_state == S_ACK);
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_widx  <= w_widx;
            r_sel   <= wbs_sel_i;
            r_wdat  <= wbs_dat_i;
            r_abort <= 1'b0;
            r_cnt   <= '0;
            if (w_oob) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              r_dat   <= {DATA_W{OOB_BIT}};
            end else if (wbs_we_i) begin
              r_state <= S_WR_WAIT;
            end else if (w_hit) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              r_hit   <= 1'b1;
              r_dat   <= r_line[w_woff];
            end else begin
              r_state  <= S_FILL_WAIT;
              r_lvalid <= 1'b0;
              r_ltag   <= w_tag;
            end
          end
        end
        S_FILL_WAIT: begin
          if (!wb_valid) r_abort <= 1'b1;
          if (w_rd_last) begin
            r_cnt   <= '0;
            r_fidx  <= '0;
            r_state <= S_FILL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FILL: begin
          r_line[r_fidx] <= w_rdata;
          r_fidx         <= w_fnext;
          if (!wb_valid) r_abort <= 1'b1;
          if (w_fill_last) begin
            r_lvalid <= 1'b1;
            if (r_abort || !wb_valid) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              r_dat   <= w_fill_word;
            end
          end
        end
        S_WR_WAIT: begin
          if (!wb_valid) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (w_wr_last) begin
            r_cnt   <= '0;
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (w_merge) begin
              for (int b = 0; b < SEL_W; b++) begin
                if (r_sel[b]) begin
                  r_line[r_woff][8*b +: 8] <= r_wdat[8*b +: 8];
                end
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign pf_hit_o  = r_hit;

endmodule

// File: tb/tb_exmem_pf.sv
// tb_exmem_pf: directed bench with a transaction-level model
// of memory, line buffer and latencies for two builds.
module tb_exmem_pf;

  localparam int          MW   = 1024;
  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam int          RDD  = 10;
  localparam int          WRD  = 2;
  localparam int          PFD  = 4;

  logic        clk;
  logic        rst_n;
  logic        valid [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] dat_i [2];
  logic [31:0] adr   [2];
  logic        ack   [2];
  logic [31:0] dat_o [2];
  logic        hit   [2];

  int n_pass;
  int n_tot;

  logic [31:0] m_mem  [2][MW];
  bit          m_lv   [2];
  int          m_tag  [2];
  logic [31:0] m_last [2];

  logic [31:0] pre [9];

  exmem_pf #(.PF_EN(1'b1)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_valid  (valid[0]),
    .wbs_we_i  (we[0]),
    .wbs_sel_i (sel[0]),
    .wbs_dat_i (dat_i[0]),
    .wbs_adr_i (adr[0]),
    .wbs_ack_o (ack[0]),
    .wbs_dat_o (dat_o[0]),
    .pf_hit_o  (hit[0])
  );

  exmem_pf #(.PF_EN(1'b0)) dut_nopf (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb_valid  (valid[1]),
    .wbs_we_i  (we[1]),
    .wbs_sel_i (sel[1]),
    .wbs_dat_i (dat_i[1]),
    .wbs_adr_i (adr[1]),
    .wbs_ack_o (ack[1]),
    .wbs_dat_o (dat_o[1]),
    .pf_hit_o  (hit[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(4 * w);
  endfunction

  // Transaction-level prediction; updates the model state.
  task automatic predict(input int d, input bit w_e,
                         input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] dat, output bit h);
    longint off;
    int     w;
    off = longint'(a) - longint'(BASE);
    h   = 1'b0;
    if (off < 0 || off / 4 >= MW) begin
      lat = 1;
      dat = 32'h0;
    end else begin
      w = int'(off / 4);
      if (w_e) begin
        lat = WRD + 1;
        for (int b = 0; b < 4; b++)
          if (s[b]) m_mem[d][w][8*b +: 8] = wd[8*b +: 8];
        dat = m_last[d];
      end else if (d == 0 && m_lv[d] && m_tag[d] == w / PFD) begin
        lat = 1;
        dat = m_mem[d][w];
        h   = 1'b1;
      end else begin
        lat = RDD + PFD + 1;
        m_lv[d]  = 1'b1;
        m_tag[d] = w / PFD;
        dat = m_mem[d][w];
      end
    end
    m_last[d] = dat;
  endtask

  task automatic xact(input int d, input bit w_e,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output int glat,
                      output logic [31:0] gd, output bit gh);
    int          elat;
    logic [31:0] ed;
    bit          eh;
    logic [31:0] prev;
    prev = m_last[d];
    predict(d, w_e, a, s, wd, elat, ed, eh);
    we[d] = w_e; adr[d] = a; sel[d] = s; dat_i[d] = wd;
    valid[d] = 1'b1;
    glat = 0;
    gd   = 32'hx;
    gh   = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        glat = c;
        gd   = dat_o[d];
        gh   = hit[d];
        break;
      end
      chk("dat_hold", dat_o[d], prev);
    end
    chk("latency", 32'(glat), 32'(elat));
    if (glat != 0) begin
      chk("dat_o", gd, ed);
      chk("pf_hit", {31'b0, gh}, {31'b0, eh});
    end
    valid[d] = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", {31'b0, ack[d]}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic abort_x(input int d, input bit w_e, input int w,
                         input logic [31:0] wd, input int ncyc);
    int nack;
    nack = 0;
    if (!w_e) begin
      m_lv[d]  = 1'b1;
      m_tag[d] = w / PFD;
    end
    we[d] = w_e; adr[d] = wa(w); sel[d] = 4'hF; dat_i[d] = wd;
    valid[d] = 1'b1;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (ack[d]) nack++;
    end
    valid[d] = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (ack[d]) nack++;
    end
    chk("abort_noack", 32'(nack), 32'h0);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lv[d]   = 1'b0;
      m_last[d] = 32'h0;
    end
  endtask

  int          lat;
  logic [31:0] gd;
  bit          gh;

  initial begin
    n_pass = 0;
    n_tot  = 0;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 0; we[d] = 0; sel[d] = 0; dat_i[d] = 0; adr[d] = 0;
      for (int i = 0; i < MW; i++) m_mem[d][i] = 32'h0;
    end
    model_reset();
    pre = '{32'h0A0B_0C0D, 32'h1234_5678, 32'h1122_3344,
            32'h5566_7788, 32'h99AA_BBCC, 32'h0F0E_0D0C,
            32'hFEDC_BA98, 32'h7654_3210, 32'h2468_ACE0};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack[0]}, 32'h0);
    chk("rst_dat", dat_o[0], 32'h0);
    chk("rst_hit", {31'b0, hit[0]}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      xact(0, 1'b1, wa(i), 4'hF, pre[i], lat, gd, gh);
    xact(1, 1'b1, wa(1), 4'hF, 32'hCAFE_F00D, lat, gd, gh);

    // Memory contents must survive a reset pulse.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    xact(0, 1'b0, wa(0), 4'h0, 32'h0, lat, gd, gh);
    chk("t1_miss_lat", 32'(lat), 32'd15);
    chk("t1_miss_dat", gd, 32'h0A0B_0C0D);
    chk("t1_miss_hit", {31'b0, gh}, 32'h0);
    xact(0, 1'b0, wa(1), 4'h0, 32'h0, lat, gd, gh);
    chk("t1_hit_lat", 32'(lat), 32'd1);
    chk("t1_hit", {31'b0, gh}, 32'h1);

    xact(0, 1'b1, wa(2), 4'b0011, 32'hDEAD_BEEF, lat, gd, gh);
    chk("t2_wr_lat", 32'(lat), 32'd3);
    xact(0, 1'b0, wa(2), 4'h0, 32'h0, lat, gd, gh);
    chk("t2_merge_dat", gd, 32'h1122_BEEF);
    chk("t2_merge_hit", {31'b0, gh}, 32'h1);

    xact(0, 1'b1, wa(3), 4'b0000, 32'hFFFF_FFFF, lat, gd, gh);
    xact(0, 1'b0, wa(3), 4'h0, 32'h0, lat, gd, gh);
    chk("sel0_dat", gd, 32'h5566_7788);

    xact(0, 1'b0, wa(4), 4'h0, 32'h0, lat, gd, gh);
    chk("t3_next_lat", 32'(lat), 32'd15);
    xact(0, 1'b0, wa(0), 4'h0, 32'h0, lat, gd, gh);
    chk("t3_evict_lat", 32'(lat), 32'd15);

    abort_x(0, 1'b0, 5, 32'h0, 5);
    xact(0, 1'b0, wa(5), 4'h0, 32'h0, lat, gd, gh);
    chk("t4_hit_lat", 32'(lat), 32'd1);

    abort_x(0, 1'b1, 6, 32'h0BAD_0BAD, 1);
    xact(0, 1'b0, wa(6), 4'h0, 32'h0, lat, gd, gh);
    chk("wr_abort_dat", gd, 32'hFEDC_BA98);

    // Reset lands while the line fill is in progress.
    we[0] = 1'b0; adr[0] = wa(0); sel[0] = 4'h0;
    valid[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("t5_rst_ack", {31'b0, ack[0]}, 32'h0);
    chk("t5_rst_dat", dat_o[0], 32'h0);
    valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    xact(0, 1'b0, wa(0), 4'h0, 32'h0, lat, gd, gh);
    chk("t5_lat", 32'(lat), 32'd15);
    chk("t5_dat", gd, 32'h0A0B_0C0D);

    xact(0, 1'b0, BASE + 32'(4 * MW), 4'h0, 32'h0, lat, gd, gh);
    chk("t6_oob_lat", 32'(lat), 32'd1);
    chk("t6_oob_dat", gd, 32'h0);
    xact(0, 1'b1, BASE + 32'(4 * MW), 4'hF, 32'hFFFF_FFFF,
         lat, gd, gh);
    xact(0, 1'b0, BASE - 32'd4, 4'h0, 32'h0, lat, gd, gh);
    xact(0, 1'b0, wa(8), 4'h0, 32'h0, lat, gd, gh);
    xact(0, 1'b0, wa(0), 4'h0, 32'h0, lat, gd, gh);
    chk("t6_sram_kept", gd, 32'h0A0B_0C0D);

    xact(0, 1'b1, wa(MW - 1), 4'hF, 32'h5A5A_A5A5, lat, gd, gh);
    xact(0, 1'b0, wa(MW - 1), 4'h0, 32'h0, lat, gd, gh);
    chk("top_word_dat", gd, 32'h5A5A_A5A5);

    xact(1, 1'b0, wa(1), 4'h0, 32'h0, lat, gd, gh);
    chk("nopf_lat1", 32'(lat), 32'd15);
    xact(1, 1'b0, wa(1), 4'h0, 32'h0, lat, gd, gh);
    chk("nopf_lat2", 32'(lat), 32'd15);
    chk("nopf_hit2", {31'b0, gh}, 32'h0);
    chk("nopf_dat2", gd, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
